// File: rtl/icb_sram_pkg.sv
// -----------------------------------------------------------------------------
// icb_sram_pkg
// Shared definitions for the ICB-to-SRAM controller:
//   - state encoding (enum typedef plus legacy 2-bit localparam constants)
//   - SRAM data width and byte-enable width
//   - byte_merge(): combines new write bytes with the old SRAM word
// -----------------------------------------------------------------------------
package icb_sram_pkg;

    localparam int SRAM_DW   = 32;
    localparam int SRAM_BE_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        RMW_RD = 2'd2,
        RMW_WR = 2'd3
    } icb_sram_state_e;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_RD     = RD;
    localparam logic [1:0] ST_RMW_RD = RMW_RD;
    localparam logic [1:0] ST_RMW_WR = RMW_WR;

    // Byte i comes from new_word when mask[i] is set, otherwise from old_word.
    function automatic logic [SRAM_DW-1:0] byte_merge(
        input logic [SRAM_DW-1:0]   new_word,
        input logic [SRAM_DW-1:0]   old_word,
        input logic [SRAM_BE_W-1:0] mask
    );
        logic [SRAM_DW-1:0] merged;
        merged = old_word;
        for (int i = 0; i < SRAM_BE_W; i++) begin
            if (mask[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                merged[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/icb_sram_rsp_reg.sv
// -----------------------------------------------------------------------------
// icb_sram_rsp_reg
// ICB response holding register. A load captures err/rdata and raises
// rsp_valid; a handshake (valid & ready) without a load drops rsp_valid.
// The stored values stay stable while valid & !ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   load                capture a new response this edge
//   load_err/load_rdata values to capture
//   rsp_ready           response accepted by the initiator
//   rsp_valid/err/rdata registered response outputs
// -----------------------------------------------------------------------------
module icb_sram_rsp_reg
    import icb_sram_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               load_err,
    input  logic [SRAM_DW-1:0] load_rdata,
    input  logic               rsp_ready,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [SRAM_DW-1:0] rsp_rdata
);

    // Response register: load has priority so an overlapping handshake and
    // new response leave the new one valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= {SRAM_DW{1'b0}};
        end else if (load) begin
            rsp_valid <= 1'b1;
            rsp_err   <= load_err;
            rsp_rdata <= load_rdata;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/icb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// icb_sram_ctrl
// ICB-lite target driving one 2**SRAM_AW x 32 synchronous SRAM with separate
// read/write ports and no byte enables. One transaction outstanding at a time.
// Optional feature macro: ICB_SRAM_RMW_EN
//   defined   : partial-mask writes use read-modify-write (RMW_RD/RMW_WR)
//   undefined : partial-mask writes return err=1 without touching the SRAM
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   icb_cmd_*                   ICB command channel (valid/ready/addr/read/
//                               wdata/wmask)
//   icb_rsp_*                   ICB response channel (valid/ready/rdata/err)
//   sram_csbn, sram_wsbn        active-low chip select / write select
//   sram_waddr/wdata, raddr     SRAM write and read ports
//   sram_rdata                  SRAM read data, valid the cycle after csbn=0
// -----------------------------------------------------------------------------
module icb_sram_ctrl
    import icb_sram_pkg::*;
#(
    parameter int SRAM_AW = 13,
    parameter int ICB_AW  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 icb_cmd_valid,
    output logic                 icb_cmd_ready,
    input  logic [ICB_AW-1:0]    icb_cmd_addr,
    input  logic                 icb_cmd_read,
    input  logic [SRAM_DW-1:0]   icb_cmd_wdata,
    input  logic [SRAM_BE_W-1:0] icb_cmd_wmask,
    output logic                 icb_rsp_valid,
    input  logic                 icb_rsp_ready,
    output logic [SRAM_DW-1:0]   icb_rsp_rdata,
    output logic                 icb_rsp_err,
    output logic                 sram_csbn,
    output logic                 sram_wsbn,
    output logic [SRAM_AW-1:0]   sram_waddr,
    output logic [SRAM_DW-1:0]   sram_wdata,
    output logic [SRAM_AW-1:0]   sram_raddr,
    input  logic [SRAM_DW-1:0]   sram_rdata
);

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic               accept_s;
    logic               err_s;
    logic               wr_full_s;
    logic               wr_part_s;
    logic [SRAM_AW-1:0] word_s;
    logic               load_s;
    logic               load_err_s;
    logic [SRAM_DW-1:0] load_rdata_s;
    logic               addr_unused_s;

    // Upper address bits are decoded by the fabric, not here.
    assign word_s        = icb_cmd_addr[SRAM_AW+1:2];
    assign addr_unused_s = ^{icb_cmd_addr[ICB_AW-1:SRAM_AW+2]};

    assign icb_cmd_ready = !rst && (state_r == ST_IDLE) &&
                           (!icb_rsp_valid || icb_rsp_ready);
    assign accept_s      = icb_cmd_valid && icb_cmd_ready;
    assign wr_full_s     = !icb_cmd_read && (icb_cmd_wmask == 4'hF);
    assign wr_part_s     = !icb_cmd_read && (icb_cmd_wmask != 4'hF) &&
                           (icb_cmd_wmask != 4'h0);

`ifdef ICB_SRAM_RMW_EN
    assign err_s = (icb_cmd_addr[1:0] != 2'b00) ||
                   (!icb_cmd_read && (icb_cmd_wmask == 4'h0));

    logic [SRAM_AW-1:0]   rmw_addr_r;
    logic [SRAM_DW-1:0]   rmw_wdata_r;
    logic [SRAM_BE_W-1:0] rmw_mask_r;
    logic [SRAM_DW-1:0]   rmw_merged_r;

    // RMW context: capture the command on accept, merge once the old word
    // arrives (SRAM output is only guaranteed valid in RMW_RD).
    always_ff @(posedge clk) begin
        if (rst) begin
            rmw_addr_r   <= {SRAM_AW{1'b0}};
            rmw_wdata_r  <= {SRAM_DW{1'b0}};
            rmw_mask_r   <= {SRAM_BE_W{1'b0}};
            rmw_merged_r <= {SRAM_DW{1'b0}};
        end else if (accept_s && wr_part_s && !err_s) begin
            rmw_addr_r  <= word_s;
            rmw_wdata_r <= icb_cmd_wdata;
            rmw_mask_r  <= icb_cmd_wmask;
        end else if (state_r == ST_RMW_RD) begin
            rmw_merged_r <= byte_merge(rmw_wdata_r, sram_rdata, rmw_mask_r);
        end
    end
`else
    assign err_s = (icb_cmd_addr[1:0] != 2'b00) ||
                   (!icb_cmd_read && (icb_cmd_wmask == 4'h0)) ||
                   wr_part_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, SRAM strobes and response load request.
    always_comb begin
        state_nxt_s  = state_r;
        sram_csbn    = 1'b1;
        sram_wsbn    = 1'b1;
        sram_waddr   = word_s;
        sram_raddr   = word_s;
        sram_wdata   = icb_cmd_wdata;
        load_s       = 1'b0;
        load_err_s   = 1'b0;
        load_rdata_s = {SRAM_DW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (err_s) begin
                        load_s      = 1'b1;
                        load_err_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else if (icb_cmd_read) begin
                        sram_csbn   = 1'b0;
                        state_nxt_s = ST_RD;
                    end else if (wr_full_s) begin
                        sram_csbn   = 1'b0;
                        sram_wsbn   = 1'b0;
                        load_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
`ifdef ICB_SRAM_RMW_EN
                        sram_csbn   = 1'b0;
                        state_nxt_s = ST_RMW_RD;
`else
                        state_nxt_s = ST_IDLE;
`endif
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                load_s       = 1'b1;
                load_rdata_s = sram_rdata;
                state_nxt_s  = ST_IDLE;
            end
`ifdef ICB_SRAM_RMW_EN
            ST_RMW_RD: begin
                state_nxt_s = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                // A reset landing here must not commit the merged word.
                sram_csbn   = rst;
                sram_wsbn   = rst;
                sram_waddr  = rmw_addr_r;
                sram_raddr  = rmw_addr_r;
                sram_wdata  = rmw_merged_r;
                load_s      = 1'b1;
                state_nxt_s = ST_IDLE;
            end
`endif
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    icb_sram_rsp_reg u_rsp_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .load_err   (load_err_s),
        .load_rdata (load_rdata_s),
        .rsp_ready  (icb_rsp_ready),
        .rsp_valid  (icb_rsp_valid),
        .rsp_err    (icb_rsp_err),
        .rsp_rdata  (icb_rsp_rdata)
    );

endmodule

// File: tb/tb_icb_sram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_icb_sram_ctrl
// Directed bench for icb_sram_ctrl with a behavioural SRAM model.
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
// -----------------------------------------------------------------------------
module tb_icb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;
    logic        sram_csbn;
    logic        sram_wsbn;
    logic [12:0] sram_waddr;
    logic [31:0] sram_wdata;
    logic [12:0] sram_raddr;
    logic [31:0] sram_rdata;

    logic [31:0] mem [0:8191];
    logic        pre_we = 1'b0;
    logic [12:0] pre_addr = 13'd0;
    logic [31:0] pre_data = 32'd0;
    int          cs_cnt = 0;
    int          wr_cnt = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    icb_sram_ctrl #(.SRAM_AW(13), .ICB_AW(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err),
        .sram_csbn     (sram_csbn),
        .sram_wsbn     (sram_wsbn),
        .sram_waddr    (sram_waddr),
        .sram_wdata    (sram_wdata),
        .sram_raddr    (sram_raddr),
        .sram_rdata    (sram_rdata)
    );

    // SRAM model: registered read, write on csbn=0 & wsbn=0; pre_we preloads.
    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else if (!sram_csbn) begin
            if (!sram_wsbn) mem[sram_waddr] <= sram_wdata;
            sram_rdata <= mem[sram_raddr];
        end
    end

    // Strobe counters for "no access" checks.
    always @(posedge clk) begin
        if (!sram_csbn) cs_cnt <= cs_cnt + 1;
        if (!sram_csbn && !sram_wsbn) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command (called at posedge+1) and check strobes at accept
    // and the response after exactly lat cycles; returns at posedge+1.
    task automatic do_cmd(input string tag, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask, input int lat,
                          input logic exp_cs, input logic exp_ws, input logic exp_err,
                          input logic [31:0] exp_rdata);
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = addr;
        icb_cmd_wdata = wdata;
        icb_cmd_wmask = mask;
        @(negedge clk);
        check({tag, "_rdy"},  {31'd0, icb_cmd_ready}, 32'd1);
        check({tag, "_csbn"}, {31'd0, sram_csbn}, {31'd0, exp_cs});
        check({tag, "_wsbn"}, {31'd0, sram_wsbn}, {31'd0, exp_ws});
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check({tag, "_early"}, {31'd0, icb_rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, icb_rsp_valid}, 32'd1);
        check({tag, "_err"},   {31'd0, icb_rsp_err}, {31'd0, exp_err});
        check({tag, "_rdata"}, icb_rsp_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp20;
        logic [31:0] hold_rdata;
        int          cnt0;
        int          idx;
        int          rcv;
        int          last;
        logic        acc;
`ifdef ICB_SRAM_RMW_EN
        exp20 = 32'h11BB33DD;
`else
        exp20 = 32'h11223344;
`endif
        rst = 1'b1;
        icb_cmd_valid = 1'b0;
        icb_cmd_addr  = 32'd0;
        icb_cmd_read  = 1'b0;
        icb_cmd_wdata = 32'd0;
        icb_cmd_wmask = 4'h0;
        icb_rsp_ready = 1'b1;

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, icb_rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'd0, icb_rsp_err}, 32'd0);
        check("rst_rsp_rdata", icb_rsp_rdata, 32'd0);
        check("rst_cmd_ready", {31'd0, icb_cmd_ready}, 32'd0);
        check("rst_csbn",      {31'd0, sram_csbn}, 32'd1);
        check("rst_wsbn",      {31'd0, sram_wsbn}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full write then read
        do_cmd("wr10", 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1'b0, 1'b0, 1'b0, 32'd0);
        check("wr10_mem", mem[4], 32'hDEADBEEF);
        do_cmd("rd10", 1'b1, 32'h10, 32'd0, 4'h0, 2, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);

        // Partial write (RMW or error)
        do_cmd("wr20", 1'b0, 32'h20, 32'h11223344, 4'hF, 1, 1'b0, 1'b0, 1'b0, 32'd0);
`ifdef ICB_SRAM_RMW_EN
        do_cmd("rmw20", 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 3, 1'b0, 1'b1, 1'b0, 32'd0);
`else
        do_cmd("rmw20", 1'b0, 32'h20, 32'hAABBCCDD, 4'b0101, 1, 1'b1, 1'b1, 1'b1, 32'd0);
`endif
        check("rmw20_mem", mem[8], exp20);
        do_cmd("rd20", 1'b1, 32'h20, 32'd0, 4'h0, 2, 1'b0, 1'b1, 1'b0, exp20);

        // Errors: misaligned read, zero-mask write
        cnt0 = cs_cnt;
        do_cmd("rd22", 1'b1, 32'h22, 32'd0, 4'h0, 1, 1'b1, 1'b1, 1'b1, 32'd0);
        check("rd22_nocs", 32'(cs_cnt - cnt0), 32'd0);
        cnt0 = cs_cnt;
        do_cmd("wrm0", 1'b0, 32'h10, 32'h01020304, 4'h0, 1, 1'b1, 1'b1, 1'b1, 32'd0);
        check("wrm0_nocs", 32'(cs_cnt - cnt0), 32'd0);
        check("wrm0_mem", mem[4], 32'hDEADBEEF);

        // Back-pressure: read 0x20 held for 5 cycles, next read presented
        icb_rsp_ready = 1'b0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h20;
        @(negedge clk);
        check("bp_rdy0", {31'd0, icb_cmd_ready}, 32'd1);
        @(posedge clk); #1;
        icb_cmd_addr = 32'h10;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, icb_rsp_valid}, 32'd1);
            check("bp_rdata", icb_rsp_rdata, exp20);
            check("bp_ready", {31'd0, icb_cmd_ready}, 32'd0);
            check("bp_csbn",  {31'd0, sram_csbn}, 32'd1);
            @(posedge clk); #1;
        end
        icb_rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_rel_ready", {31'd0, icb_cmd_ready}, 32'd1);
        check("bp_rel_csbn",  {31'd0, sram_csbn}, 32'd0);
        check("bp_rel_raddr", {19'd0, sram_raddr}, 32'd4);
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_gap", {31'd0, icb_rsp_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_rd_valid", {31'd0, icb_rsp_valid}, 32'd1);
        check("bp_rd_rdata", icb_rsp_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Reset one cycle after a partial-write accept
        cnt0 = wr_cnt;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b0;
        icb_cmd_addr  = 32'h10;
        icb_cmd_wdata = 32'hFFFFFFFF;
        icb_cmd_wmask = 4'b0001;
        @(posedge clk); #1;
        icb_cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rstm_valid", {31'd0, icb_rsp_valid}, 32'd0);
            @(posedge clk); #1;
        end
        check("rstm_nowr", 32'(wr_cnt - cnt0), 32'd0);
        check("rstm_mem", mem[4], 32'hDEADBEEF);

        // Streaming reads of a preloaded region
        for (int i = 0; i < 16; i++) begin
            pre_we   = 1'b1;
            pre_addr = 13'(i);
            pre_data = 32'hA5000000 + 32'(i);
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        idx  = 0;
        rcv  = 0;
        last = 0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = 1'b1;
        icb_cmd_addr  = 32'h0;
        for (int cyc = 0; cyc < 48 && rcv < 16; cyc++) begin
            @(negedge clk);
            if (icb_rsp_valid) begin
                check("stream_data", icb_rsp_rdata, 32'hA5000000 + 32'(rcv));
                rcv++;
            end
            acc = icb_cmd_valid && icb_cmd_ready;
            if (acc) begin
                if (idx > 0) check("stream_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                idx++;
            end
            @(posedge clk); #1;
            if (acc) begin
                if (idx == 16) icb_cmd_valid = 1'b0;
                else icb_cmd_addr = 32'(idx * 4);
            end
        end
        icb_cmd_valid = 1'b0;
        check("stream_acc", 32'(idx), 32'd16);
        check("stream_rsp", 32'(rcv), 32'd16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icb_sram_ctrl.md
Name: icb_sram_ctrl

Overview:
ICB-lite target that acts as the initiator for one 8K x 32 synchronous SRAM macro with a separate write port and read port. It accepts single-beat ICB commands and drives the SRAM's active-low chip-select and write-select. It returns read data and write acknowledgements on the ICB response channel. Sub-word writes are handled by read-modify-write, since the SRAM has no byte enables. The block sits between the E203 ICB fabric and an ITCM/DTCM-style SRAM bank.

Parameters:
SRAM_AW, 13, SRAM word-address width; SRAM depth is 2**SRAM_AW words.
ICB_AW, 32, ICB byte-address width.

Ports:
clk  input  1  clock.
rst  input  1  synchronous reset, active-high.
icb_cmd_valid  input  1  command valid.
icb_cmd_ready  output  1  command accepted when valid & ready.
icb_cmd_addr  input  ICB_AW  byte address.
icb_cmd_read  input  1  1 = read, 0 = write.
icb_cmd_wdata  input  32  write data.
icb_cmd_wmask  input  4  byte enables; bit i covers byte i.
icb_rsp_valid  output  1  response valid.
icb_rsp_ready  input  1  response accepted.
icb_rsp_rdata  output  32  read data; 0 for writes and errors.
icb_rsp_err  output  1  error response.
sram_csbn  output  1  SRAM enable, active low; required for both read and write.
sram_wsbn  output  1  SRAM write enable, active low.
sram_waddr  output  SRAM_AW  write word address.
sram_wdata  output  32  write data.
sram_raddr  output  SRAM_AW  read word address.
sram_rdata  input  32  read data, registered inside the SRAM; valid the cycle after csbn=0.

Behaviour:
- Reset and interface rules
  - One clock, clk. Reset is synchronous and active-high (rst).
  - Reset values: icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, state=IDLE, icb_cmd_ready=0.
  - SRAM outputs are combinational from state; in IDLE with no accept, csbn=1 and wsbn=1.
  - Reset mid-operation aborts any pending RMW or response; no SRAM write is issued after the reset cycle.
- Outstanding transactions and ready
  - At most one transaction is outstanding.
  - icb_cmd_ready = (state==IDLE) & (!icb_rsp_valid | icb_rsp_ready), so back-to-back commands are possible when the response is taken the same cycle.
  - Word address = icb_cmd_addr[SRAM_AW+1:2]; upper address bits are ignored (decoding is the fabric's job).
- State machine: IDLE, RD, RMW_RD, RMW_WR.
  - IDLE, error accept: accept with icb_cmd_addr[1:0]!=0, or a write with wmask==0 → no SRAM access; next cycle rsp_valid=1, err=1, rdata=0.
  - IDLE, read accept: csbn=0, wsbn=1, raddr=word → RD. In RD, rsp_rdata<=sram_rdata, rsp_valid<=1 → IDLE. Read latency: accept in cycle T, response visible in T+2.
  - IDLE, write accept with wmask==4'hF: csbn=0, wsbn=0, waddr=raddr=word, wdata=icb_cmd_wdata. Response (err=0) appears in T+1.
  - IDLE, write accept with partial mask: latch addr, wdata and mask; csbn=0, wsbn=1 → RMW_RD.
    - RMW_RD: merge each byte i as mask[i] ? wdata byte : sram_rdata byte → RMW_WR.
    - RMW_WR: csbn=0, wsbn=0, write the merged word, set the response → IDLE. The response appears in T+3.
- Response hold: the response register holds stable while rsp_valid & !rsp_ready. The SRAM is never accessed while a response is pending, except in the accept cycle when rsp_ready=1 in that same cycle.
- Simultaneous events: rsp handshake and cmd accept in one cycle are legal; the new response overwrites the old one on the next edge.
- Ordering: a read of an address just written, even by RMW, returns the new data, because commands are serialised.

Optional Feature:
ICB_SRAM_RMW_EN.
- Defined: partial-mask writes use read-modify-write as described above.
- Undefined: the RMW_RD and RMW_WR states are not compiled. A partial-mask write performs no SRAM access and returns err=1 one cycle after accept. Full-mask writes and reads are unchanged.

Decomposition:
- Package icb_sram_pkg holds:
  - the state enum typedef (IDLE, RD, RMW_RD, RMW_WR);
  - constant SRAM_DW=32;
  - constant SRAM_BE_W=4;
  - the byte-merge function.
- One natural sub-module, icb_sram_rsp_reg: the response holding register (valid/err/rdata), with load and handshake-clear.

Test Plan:
- Full write then read: write addr 0x10, data 0xDEADBEEF, mask F → rsp in T+1, err=0; read 0x10 → rsp T+2, rdata 0xDEADBEEF.
- RMW: preload 0x11223344 at 0x20; write 0xAABBCCDD, mask 0101 → read back 0x11BB33DD. Response is 3 cycles after accept (err=1 when the macro is off).
- Back-pressure: read with rsp_ready=0 for 5 cycles → rsp_rdata stable, cmd_ready=0, csbn=1 throughout; release → next command accepted in the same cycle.
- Errors: read at 0x22 → err=1, rdata=0, no csbn pulse; write with mask 0 → err=1, memory unchanged.
- Reset mid-RMW: assert rst in RMW_RD → no wsbn pulse, rsp_valid=0, the target word keeps its old value.
- Streaming: 16 reads to 0x0..0x3C with rsp_ready=1 → one accept every 2 cycles, data in order.
